rv_instr_encoder: RTL and testbench
===================================

// Module: rv_instr_encoder
// PURPOSE
// Streaming RV32I instruction encoder and program loader; the inverse of the single-cycle
// control decoder. Accepts decoded instruction descriptors (kind, ALU op, registers,
// immediate) over a valid/ready stream. Encodes each into a 32-bit instruction word and
// writes it to consecutive instruction-memory words. Used by the bench/boot path to
// build programs covering exactly the subset the core decodes: lw, sw, add/sub/slt/or/and, beq.
// PARAMETERS
// AW        6    instruction-memory word-address width
// BASE_ADDR 0    first word address written after start
// DEPTH     64   words available from BASE_ADDR (BASE_ADDR+DEPTH <= 2**AW)
// PORTS
// clk        in   1   clock, rising edge
// rst_n      in   1   asynchronous active-low reset
// start      in   1   begin a load session (pulse)
// in_valid   in   1   descriptor valid
// in_ready   out  1   encoder can accept descriptor
// in_kind    in   2   00 LW, 01 SW, 10 RTYPE, 11 BEQ
// in_alu     in   3   RTYPE only: 000 add, 001 sub, 101 slt, 011 or, 010 and (ALUControl codes)
// in_rd      in   5   destination register (LW, RTYPE)
// in_rs1     in   5   source 1
// in_rs2     in   5   source 2 (SW, RTYPE, BEQ)
// in_imm     in   13  signed immediate; byte offset for LW/SW, branch offset for BEQ
// in_last    in   1   descriptor is final of program
// imem_we    out  1   instruction-memory write strobe
// imem_addr  out  AW  word address of write
// imem_wdata out  32  encoded instruction word
// count      out  AW+1 words written this session
// done       out  1   session finished (level)
// err        out  1   sticky: illegal descriptor or overflow seen this session
// BEHAVIOUR
// - Reset: state IDLE; in_ready, imem_we, done, err = 0; imem_addr = BASE_ADDR; wdata, count = 0.
// - FSM IDLE -> RUN on start; DONE -> RUN on start (clears done, err, count, addr=BASE_ADDR).
//   start in RUN ignored. RUN -> DONE after the write of an accepted in_last descriptor,
//   or after the write to BASE_ADDR+DEPTH-1 (overflow guard; err set if that word lacked in_last).
// - in_ready = 1 only in RUN and not in the cycle the final (last/full) write is pending.
// - Accept on in_valid & in_ready; one descriptor per cycle sustained.
// - Latency 1: descriptor accepted at edge N -> imem_we=1 with addr/wdata during cycle N+1.
//   Address increments after each write; count increments with each write.
// - Encodings: LW  {imm[11:0],rs1,010,rd,0000011}
//   SW  {imm[11:5],rs2,rs1,010,imm[4:0],0100011}
//   R   {f7,rs2,rs1,f3,rd,0110011}; add 000/0000000, sub 000/0100000, slt 010, or 110, and 111
//   BEQ {imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011}
// - Illegal descriptor (RTYPE with unlisted in_alu; LW/SW with imm[12]!=imm[11]; BEQ with
//   imm[0]=1): accepted (consumed), no write, no address advance, err set. If it carries in_last,
//   FSM still goes to DONE next cycle.
// - in_valid outside RUN: ignored, nothing consumed. No write ever exceeds BASE_ADDR+DEPTH-1.
// - rst_n low mid-session: immediate return to reset values; pending write dropped.
// STRUCTURE
// - Package rv_isa_pkg: opcode constants (OP_LW, OP_SW, OP_R, OP_BEQ), funct3/funct7 values,
//   kind codes, ALUControl codes shared with the control decoder.
// - Sub-module rv_instr_pack: purely combinational descriptor -> {word, illegal}; this block
//   holds the FSM, output register, address/count counters.
// TESTING
// - LW rd=5 rs1=2 imm=8, last -> one write addr 0 data 0x00812283; done=1, count=1, err=0.
// - Burst no gaps: SW rs2=6 rs1=3 imm=4; RTYPE sub rd=1 rs1=2 rs2=3; RTYPE and rd=4 rs1=5 rs2=6;
//   BEQ rs1=1 rs2=2 imm=-8 last -> addrs 0..3 data 0x0061A223, 0x403100B3, 0x0062F233,
//   0xFE208CE3 on consecutive cycles.
// - RTYPE in_alu=100, then LW valid last -> no write for first, LW at addr 0, err=1, count=1.
// - DEPTH=4, 6 valid non-last descriptors -> 4 writes addr 0..3, in_ready low after 4th, done=1, err=1.
// - rst_n low in cycle after an accept -> no imem_we, all outputs reset; start again begins at addr 0.
// - in_valid held during IDLE/DONE and start during RUN -> no writes, no session restart.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants for the lw/sw/R-type/beq subset, plus the descriptor
// kind codes and ALUControl codes shared with the single-cycle control decoder.
package rv_isa_pkg;

  // Descriptor kind as presented on the input stream
  typedef enum logic [1:0] {
    KIND_LW    = 2'b00,
    KIND_SW    = 2'b01,
    KIND_RTYPE = 2'b10,
    KIND_BEQ   = 2'b11
  } kind_e;

  // Load-session control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Major opcodes
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_WORD    = 3'b010;  // lw / sw
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // ALUControl codes used by the decoder for R-type operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational descriptor -> 32-bit instruction word, flagging descriptors that
// cannot be represented in the supported subset.
module rv_instr_pack
  import rv_isa_pkg::*;
(
  input  kind_e       kind,
  input  logic [2:0]  alu,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Assemble the instruction fields for the requested kind
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_LW: begin
        word    = {imm[11:0], rs1, F3_WORD, rd, OP_LW};
        // 12-bit I-immediate: bit 12 must be a copy of the sign bit 11
        illegal = imm[12] ^ imm[11];
      end
      KIND_SW: begin
        word    = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_SW};
        illegal = imm[12] ^ imm[11];
      end
      KIND_RTYPE: begin
        case (alu)
          ALU_ADD: word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OP_R};
          ALU_SUB: word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OP_R};
          ALU_SLT: word = {F7_BASE, rs2, rs1, F3_SLT,     rd, OP_R};
          ALU_OR:  word = {F7_BASE, rs2, rs1, F3_OR,      rd, OP_R};
          ALU_AND: word = {F7_BASE, rs2, rs1, F3_AND,     rd, OP_R};
          default: illegal = 1'b1;
        endcase
      end
      KIND_BEQ: begin
        word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BEQ};
        // branch targets are halfword aligned; bit 0 is not encodable
        illegal = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// Streaming instruction encoder / program loader: accepts descriptors while a
// session runs, writes one encoded word per accepted legal descriptor to
// consecutive instruction-memory addresses, and stops on in_last or when full.
module rv_instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int AW        = 6,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_kind,
  input  logic [2:0]    in_alu,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [12:0]   in_imm,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] FIRST_ADDR = AW'(BASE_ADDR);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(BASE_ADDR + DEPTH - 1);

  state_e        state, state_next;
  logic          final_pending;   // last/full descriptor taken; session ends next edge
  logic [31:0]   word;
  logic          illegal;
  logic          accept;
  logic          session_start;
  logic [AW-1:0] wr_addr;         // address the next accepted legal word lands on
  logic          hits_last;

  rv_instr_pack u_pack (
    .kind    (kind_e'(in_kind)),
    .alu     (in_alu),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (word),
    .illegal (illegal)
  );

  assign in_ready      = (state == ST_RUN) && !final_pending;
  assign accept        = in_valid && in_ready;
  assign session_start = start && (state != ST_RUN);
  // imem_addr only advances once the pending write retires, so look one ahead
  assign wr_addr       = imem_we ? imem_addr + AW'(1) : imem_addr;
  assign hits_last     = (wr_addr == LAST_ADDR);
  assign done          = (state == ST_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state: sessions start from IDLE/DONE and end the edge after the final accept
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (final_pending) state_next = ST_DONE;
      ST_DONE: if (start) state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  // Write register, address/count counters and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we       <= 1'b0;
      imem_addr     <= FIRST_ADDR;
      imem_wdata    <= '0;
      count         <= '0;
      err           <= 1'b0;
      final_pending <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments: every read below sees pre-edge values.
      imem_we <= accept && !illegal;
      if (imem_we) begin
        imem_addr <= imem_addr + AW'(1);
        count     <= count + (AW+1)'(1);
      end
      if (final_pending) final_pending <= 1'b0;
      if (accept) begin
        if (!illegal) imem_wdata <= word;
        if (illegal || (hits_last && !in_last)) err <= 1'b1;
        if (in_last || (!illegal && hits_last)) final_pending <= 1'b1;
      end
      if (session_start) begin
        imem_we       <= 1'b0;
        imem_addr     <= FIRST_ADDR;
        count         <= '0;
        err           <= 1'b0;
        final_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder: a DEPTH=64 instance for encodings and
// session control, and a DEPTH=4 instance sharing the same stimulus for overflow.
module tb_rv_instr_encoder;
  import rv_isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [1:0]  in_kind;
  logic [2:0]  in_alu;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;
  logic        in_last;

  logic        ready0, we0, done0, err0;
  logic [5:0]  addr0;
  logic [31:0] wdata0;
  logic [6:0]  count0;
  logic        ready1, we1, done1, err1;
  logic [5:0]  addr1;
  logic [31:0] wdata1;
  logic [6:0]  count1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] q0_addr[$], q0_data[$], q1_addr[$];
  int          q0_cyc[$];

  always #5 clk = ~clk;

  rv_instr_encoder #(.AW(6), .BASE_ADDR(0), .DEPTH(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready0),
    .in_kind(in_kind), .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .imem_we(we0), .imem_addr(addr0),
    .imem_wdata(wdata0), .count(count0), .done(done0), .err(err0)
  );

  rv_instr_encoder #(.AW(6), .BASE_ADDR(0), .DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ready1),
    .in_kind(in_kind), .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .imem_we(we1), .imem_addr(addr1),
    .imem_wdata(wdata1), .count(count1), .done(done1), .err(err1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (we0) begin
      q0_addr.push_back(32'(addr0));
      q0_data.push_back(wdata0);
      q0_cyc.push_back(cyc);
    end
    if (we1) q1_addr.push_back(32'(addr1));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q0_addr.delete(); q0_data.delete(); q0_cyc.delete(); q1_addr.delete();
  endtask

  task automatic drive(input logic [1:0] kind, input logic [2:0] alu, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                       input logic last);
    in_valid = 1'b1; in_kind = kind; in_alu = alu; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done0(input string tag);
    for (int i = 0; i < 20 && !done0; i++) tick();
    check(tag, 32'(done0), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    in_valid = 1'b0; in_kind = '0; in_alu = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_ready", 32'(ready0), 32'd0);
    check("rst_we",    32'(we0),    32'd0);
    check("rst_done",  32'(done0),  32'd0);
    check("rst_err",   32'(err0),   32'd0);
    check("rst_addr",  32'(addr0),  32'd0);
    check("rst_wdata", wdata0,      32'd0);
    check("rst_count", 32'(count0), 32'd0);

    // Single LW with last
    pulse_start();
    check("lw_ready", 32'(ready0), 32'd1);
    drive(KIND_LW, 3'b000, 5'd5, 5'd2, 5'd0, 13'd8, 1'b1);
    tick();
    idle_in();
    check("lw_we",         32'(we0),    32'd1);
    check("lw_addr",       32'(addr0),  32'd0);
    check("lw_data",       wdata0,      32'h00812283);
    check("lw_ready_fin",  32'(ready0), 32'd0);
    tick();
    check("lw_done",  32'(done0),  32'd1);
    check("lw_count", 32'(count0), 32'd1);
    check("lw_err",   32'(err0),   32'd0);
    check("lw_we_off", 32'(we0),   32'd0);

    // Back-to-back burst: SW, sub, and, BEQ(last)
    clear_q();
    pulse_start();
    check("burst_restart_done", 32'(done0), 32'd0);
    drive(KIND_SW, 3'b000, 5'd0, 5'd3, 5'd6, 13'd4, 1'b0);
    tick();
    drive(KIND_RTYPE, ALU_SUB, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0);
    tick();
    drive(KIND_RTYPE, ALU_AND, 5'd4, 5'd5, 5'd6, 13'd0, 1'b0);
    tick();
    drive(KIND_BEQ, 3'b000, 5'd0, 5'd1, 5'd2, -13'sd8, 1'b1);
    tick();
    idle_in();
    wait_done0("burst_done");
    check("burst_nwr", q0_addr.size(), 32'd4);
    if (q0_addr.size() == 4) begin
      logic [31:0] exp_data [4];
      exp_data = '{32'h0061A223, 32'h403100B3, 32'h0062F233, 32'hFE208CE3};
      for (int i = 0; i < 4; i++) begin
        check($sformatf("burst_addr%0d", i), q0_addr[i], 32'(i));
        check($sformatf("burst_data%0d", i), q0_data[i], exp_data[i]);
        if (i > 0) check($sformatf("burst_gap%0d", i), 32'(q0_cyc[i] - q0_cyc[i-1]), 32'd1);
      end
    end
    check("burst_count", 32'(count0), 32'd4);
    check("burst_err",   32'(err0),   32'd0);

    // Illegal R-type followed by LW last
    clear_q();
    pulse_start();
    drive(KIND_RTYPE, 3'b100, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0);
    tick();
    check("ill_no_we", 32'(we0), 32'd0);
    drive(KIND_LW, 3'b000, 5'd5, 5'd2, 5'd0, 13'd8, 1'b1);
    tick();
    idle_in();
    wait_done0("ill_done");
    check("ill_nwr", q0_addr.size(), 32'd1);
    if (q0_addr.size() == 1) begin
      check("ill_addr", q0_addr[0], 32'd0);
      check("ill_data", q0_data[0], 32'h00812283);
    end
    check("ill_err",   32'(err0),   32'd1);
    check("ill_count", 32'(count0), 32'd1);

    // Overflow on the DEPTH=4 instance: six non-last descriptors
    clear_q();
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      drive(KIND_LW, 3'b000, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0);
      tick();
      if (i == 3) check("ovf_ready_low", 32'(ready1), 32'd0);
    end
    idle_in();
    tick();
    check("ovf_nwr", q1_addr.size(), 32'd4);
    if (q1_addr.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("ovf_addr%0d", i), q1_addr[i], 32'(i));
    check("ovf_done",  32'(done1),  32'd1);
    check("ovf_err",   32'(err1),   32'd1);
    check("ovf_count", 32'(count1), 32'd4);

    // Reset in the cycle after an accept
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    clear_q();
    pulse_start();
    drive(KIND_LW, 3'b000, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0);
    tick();
    idle_in();
    rst_n = 1'b0;
    #1;
    check("mrst_we",    32'(we0),    32'd0);
    check("mrst_addr",  32'(addr0),  32'd0);
    check("mrst_wdata", wdata0,      32'd0);
    check("mrst_count", 32'(count0), 32'd0);
    check("mrst_ready", 32'(ready0), 32'd0);
    tick();
    check("mrst_nwr", q0_addr.size(), 32'd0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    drive(KIND_LW, 3'b000, 5'd5, 5'd2, 5'd0, 13'd8, 1'b1);
    tick();
    idle_in();
    check("mrst_re_addr", 32'(addr0), 32'd0);
    check("mrst_re_we",   32'(we0),   32'd1);
    wait_done0("mrst_re_done");

    // in_valid in DONE and IDLE, start during RUN
    clear_q();
    drive(KIND_LW, 3'b000, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0);
    repeat (3) tick();
    check("hold_done_nwr",   q0_addr.size(), 32'd0);
    check("hold_done_count", 32'(count0),    32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (3) tick();
    check("hold_idle_ready", 32'(ready0),    32'd0);
    check("hold_idle_nwr",   q0_addr.size(), 32'd0);
    idle_in();
    pulse_start();
    drive(KIND_LW, 3'b000, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0);
    tick();
    start = 1'b1;
    drive(KIND_SW, 3'b000, 5'd0, 5'd3, 5'd6, 13'd4, 1'b1);
    tick();
    start = 1'b0;
    idle_in();
    wait_done0("srun_done");
    check("srun_nwr", q0_addr.size(), 32'd2);
    if (q0_addr.size() == 2) begin
      check("srun_addr1", q0_addr[1], 32'd1);
      check("srun_data1", q0_data[1], 32'h0061A223);
    end
    check("srun_count", 32'(count0), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
